// File: rtl/aidan_mcnay_prime_ctrl_if.sv
// Handshake bundle between the prime controller, its candidate/verdict streams
// and the attached iterative divider.
interface aidan_mcnay_prime_ctrl_if #(
  parameter int unsigned p_nbits = 16
);
  // Candidate input stream
  logic [p_nbits-1:0] istream_msg;
  logic               istream_val;
  logic               istream_rdy;
  // Verdict output stream
  logic               ostream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  // Divider request/response
  logic [p_nbits-1:0] div_opa;
  logic [p_nbits-1:0] div_opb;
  logic               div_istream_val;
  logic               div_istream_rdy;
  logic [p_nbits-1:0] div_result;
  logic               div_ostream_val;
  logic               div_ostream_rdy;

  // Controller side
  modport master (
    input  istream_msg, istream_val, ostream_rdy, div_istream_rdy, div_result, div_ostream_val,
    output istream_rdy, ostream_msg, ostream_val, div_opa, div_opb, div_istream_val,
    output div_ostream_rdy
  );

  // Environment side: candidate source, verdict sink and divider
  modport slave (
    output istream_msg, istream_val, ostream_rdy, div_istream_rdy, div_result, div_ostream_val,
    input  istream_rdy, ostream_msg, ostream_val, div_opa, div_opb, div_istream_val,
    input  div_ostream_rdy
  );
endinterface

// File: rtl/aidan_mcnay_prime_ctrl.sv
// Trial-division prime checker controller. Walks d = 2, 3, ... while d*d <= n,
// asking the divider for n mod d; any zero remainder means composite.
module aidan_mcnay_prime_ctrl #(
  parameter int unsigned p_nbits = 16
) (
  input logic                      clk,
  input logic                      reset,
  aidan_mcnay_prime_ctrl_if.master bus
);

  typedef enum logic [2:0] {StIdle, StCheck, StSend, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [p_nbits-1:0]   n_q, n_d;
  logic [p_nbits-1:0]   d_q, d_d;
  logic [2*p_nbits-1:0] sq_q, sq_d;  // always d_q * d_q
  logic                 verdict_q, verdict_d;

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      n_q       <= '0;
      d_q       <= p_nbits'(2);
      sq_q      <= (2*p_nbits)'(4);
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      sq_q      <= sq_d;
      verdict_q <= verdict_d;
    end
  end

  // Next-state logic; outputs decoded from state only
  always_comb begin
    state_d             = state_q;
    n_d                 = n_q;
    d_d                 = d_q;
    sq_d                = sq_q;
    verdict_d           = verdict_q;
    bus.istream_rdy     = 1'b0;
    bus.ostream_msg     = 1'b0;
    bus.ostream_val     = 1'b0;
    bus.div_opa         = '0;
    bus.div_opb         = '0;
    bus.div_istream_val = 1'b0;
    bus.div_ostream_rdy = 1'b0;

    case (state_q)
      StIdle: begin
        bus.istream_rdy = 1'b1;
        if (bus.istream_val) begin
          n_d     = bus.istream_msg;
          d_d     = p_nbits'(2);
          sq_d    = (2*p_nbits)'(4);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (n_q < p_nbits'(2)) begin
          verdict_d = 1'b0;
          state_d   = StDone;
        end else if (sq_q > {{p_nbits{1'b0}}, n_q}) begin
          // No divisor up to sqrt(n) was found
          verdict_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d = StSend;
        end
      end
      StSend: begin
        bus.div_istream_val = 1'b1;
        bus.div_opa         = n_q;
        bus.div_opb         = d_q;
        if (bus.div_istream_rdy) state_d = StWait;
      end
      StWait: begin
        bus.div_ostream_rdy = 1'b1;
        if (bus.div_ostream_val) begin
          if (bus.div_result == '0) begin
            verdict_d = 1'b0;
            state_d   = StDone;
          end else begin
            // (d+1)^2 = d^2 + 2d + 1
            d_d     = d_q + p_nbits'(1);
            sq_d    = sq_q + {{(p_nbits-1){1'b0}}, d_q, 1'b1};
            state_d = StCheck;
          end
        end
      end
      StDone: begin
        bus.ostream_val = 1'b1;
        bus.ostream_msg = verdict_q;
        if (bus.ostream_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
// Bench for the prime controller: behavioural divider and verdict sink, a
// trial-division reference model, per-cycle output checks and literal pins.
module tb_aidan_mcnay_prime_ctrl;

  logic clk;
  logic reset;

  aidan_mcnay_prime_ctrl_if #(.p_nbits(16)) bus ();

  aidan_mcnay_prime_ctrl #(.p_nbits(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall    = 0;

  // Reference model state (owned by the main process)
  int cur_n;
  int exp_d[300];
  int exp_n;
  bit exp_verdict;
  bit busy;
  int req_idx;
  int done_cnt;
  bit last_verdict;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: divisors tried in order, stopping at the first exact one
  task automatic build_model(input int n);
    cur_n       = n;
    exp_n       = 0;
    exp_verdict = (n >= 2);
    for (int d = 2; d * d <= n; d++) begin
      exp_d[exp_n] = d;
      exp_n++;
      if (n % d == 0) begin
        exp_verdict = 0;
        break;
      end
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  task automatic monitor();
    chk("istream_rdy", 32'(bus.istream_rdy), 32'(!busy));
    if (bus.div_istream_val) begin
      chk("div_opa", 32'(bus.div_opa), 32'(cur_n));
      chk("req_in_range", 32'(req_idx < exp_n), 32'd1);
      if (req_idx < exp_n) chk("div_opb", 32'(bus.div_opb), 32'(exp_d[req_idx]));
      if (bus.div_istream_rdy) req_idx++;
    end
    if (bus.ostream_val) begin
      chk("ostream_msg", 32'(bus.ostream_msg), 32'(exp_verdict));
      chk("reqs_before_verdict", 32'(req_idx), 32'(exp_n));
      if (bus.ostream_rdy) begin
        done_cnt++;
        last_verdict = bus.ostream_msg;
        busy = 0;
      end
    end
    if (bus.istream_val && bus.istream_rdy) begin
      busy    = 1;
      req_idx = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_istream_rdy", 32'(bus.istream_rdy), 32'd1);
    chk("rst_ostream_val", 32'(bus.ostream_val), 32'd0);
    chk("rst_ostream_msg", 32'(bus.ostream_msg), 32'd0);
    chk("rst_div_istream_val", 32'(bus.div_istream_val), 32'd0);
    chk("rst_div_ostream_rdy", 32'(bus.div_ostream_rdy), 32'd0);
    chk("rst_div_opa", 32'(bus.div_opa), 32'd0);
    chk("rst_div_opb", 32'(bus.div_opb), 32'd0);
  endtask

  task automatic send_cand(input int n);
    bit ok;
    build_model(n);
    bus.istream_msg = 16'(n);
    bus.istream_val = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy) begin
        ok = 1;
        break;
      end
    end
    bus.istream_val = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  // One candidate end to end; lit_reqs/lit_msg are hand-computed
  task automatic run_cand(input int n, input int lit_reqs, input bit lit_msg);
    bit ok;
    int start;
    send_cand(n);
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (done_cnt != start) begin
        ok = 1;
        break;
      end
    end
    chk("verdict_timeout", 32'(ok), 32'd1);
    chk("verdict_literal", 32'(last_verdict), 32'(lit_msg));
    chk("req_count_literal", 32'(req_idx), 32'(lit_reqs));
  endtask

  // Abort n=97 while waiting on the divider
  task automatic reset_in_wait();
    bit ok;
    send_cand(97);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.div_ostream_rdy) begin
        ok = 1;
        break;
      end
      monitor();
      @(posedge clk);
      #1;
    end
    chk("reach_wait", 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    busy = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Behavioural divider: accepts a request, answers n mod d after a latency
  bit          req_go, rsp_go, pending;
  logic [15:0] a_s, b_s, rem;
  int          cnt;
  initial begin
    bus.div_istream_rdy = 1'b0;
    bus.div_ostream_val = 1'b0;
    bus.div_result      = '0;
    pending = 0;
    cnt     = 0;
    rem     = '0;
    forever begin
      @(negedge clk);
      req_go = bus.div_istream_val && bus.div_istream_rdy;
      rsp_go = bus.div_ostream_val && bus.div_ostream_rdy;
      a_s    = bus.div_opa;
      b_s    = bus.div_opb;
      @(posedge clk);
      #1;
      if (!reset) begin
        pending             = 0;
        bus.div_ostream_val = 1'b0;
        bus.div_istream_rdy = 1'b0;
      end else begin
        if (rsp_go) begin
          bus.div_ostream_val = 1'b0;
          pending = 0;
        end
        if (req_go) begin
          pending = 1;
          rem     = (b_s == 0) ? 16'd0 : a_s % b_s;
          cnt     = stall ? int'($urandom_range(0, 5)) : 1;
        end
        if (pending && !bus.div_ostream_val) begin
          if (cnt == 0) begin
            bus.div_ostream_val = 1'b1;
            bus.div_result      = rem;
          end else begin
            cnt--;
          end
        end
        bus.div_istream_rdy = !pending && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      end
    end
  end

  // Verdict sink with optional backpressure
  initial begin
    bus.ostream_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ostream_rdy = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  initial begin
    reset           = 1'b0;
    bus.istream_val = 1'b0;
    bus.istream_msg = '0;
    busy            = 0;
    req_idx         = 0;
    done_cnt        = 0;
    last_verdict    = 0;
    build_model(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;

    run_cand(0, 0, 0);
    run_cand(1, 0, 0);
    run_cand(2, 0, 1);
    run_cand(3, 0, 1);
    run_cand(4, 1, 0);
    run_cand(97, 8, 1);
    run_cand(91, 6, 0);
    run_cand(65521, 254, 1);
    run_cand(65535, 2, 0);

    stall = 1;
    run_cand(97, 8, 1);
    run_cand(91, 6, 0);
    run_cand(4, 1, 0);
    run_cand(2, 0, 1);
    run_cand(1021, 30, 1);
    run_cand(25, 4, 0);

    stall = 0;
    reset_in_wait();
    run_cand(5, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
